// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, divider floor and frame defaults
// for the RX controller and a future TX controller.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_e;

    localparam logic [15:0] MinDivider    = 16'd2;
    localparam int unsigned DefOverSample = 8;
    localparam int unsigned DefDataBits   = 8;

    function automatic logic [15:0] clamp_divider(input logic [15:0] div);
        return (div < MinDivider) ? MinDivider : div;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer with a configurable reset value, for asynchronous
// serial-side inputs such as RX and CTS.
module uart_sync2 #(
    parameter logic ResetVal = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: drives the baud prescaler, oversamples the RX line
// and hands completed bytes to the consumer over a valid/ready holding register.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned OverSample     = DefOverSample,
    parameter int unsigned DataBits       = DefDataBits,
    parameter logic [15:0] DefaultDivider = 16'd16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_en,
    input  logic [15:0]         i_divider,
    input  logic                i_rx,
    input  logic                i_presc_strobe,
    output logic                o_presc_en,
    output logic [15:0]         o_presc_scaler,
    output logic [DataBits-1:0] o_data,
    output logic                o_valid,
    input  logic                i_ready,
    output logic                o_frame_err,
    output logic                o_overrun,
    output logic                o_busy
);

    localparam int unsigned TickW = $clog2(OverSample);
    localparam int unsigned BitW  = $clog2(DataBits + 1);

    localparam logic [TickW-1:0] TickMid  = TickW'(OverSample / 2 - 1);
    localparam logic [TickW-1:0] TickLast = TickW'(OverSample - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(DataBits - 1);

    rx_state_e             state_q, state_d;
    logic [TickW-1:0]      tick_cnt_q, tick_cnt_d;
    logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DataBits-1:0]   shreg_q, shreg_d;
    logic                  presc_en_q;
    logic [15:0]           scaler_q;
    logic [DataBits-1:0]   data_q;
    logic                  valid_q;
    logic                  frame_err_q, frame_err_d;
    logic                  overrun_q;
    logic                  deliver;
    logic                  rx_s;
    logic                  tick;

    uart_sync2 #(.ResetVal(1'b1)) u_rx_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_rx),
        .o_q   (rx_s)
    );

    // A disabled prescaler freezes with its strobe possibly stuck high.
    assign tick = i_presc_strobe & presc_en_q;

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        deliver     = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d    = START;
                    tick_cnt_d = '0;
                end
            end
            START: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + TickW'(1);
                    if (tick_cnt_q == TickMid) begin
                        if (rx_s) begin
                            state_d = IDLE;
                        end else begin
                            state_d    = DATA;
                            tick_cnt_d = '0;
                            bit_cnt_d  = '0;
                        end
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + TickW'(1);
                    if (tick_cnt_q == TickLast) begin
                        shreg_d   = {rx_s, shreg_q[DataBits-1:1]};
                        bit_cnt_d = bit_cnt_q + BitW'(1);
                        if (bit_cnt_q == BitLast) begin
                            state_d = STOP;
                        end
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + TickW'(1);
                    if (tick_cnt_q == TickLast) begin
                        if (rx_s) begin
                            deliver = 1'b1;
                            state_d = IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = BREAK;
                        end
                    end
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Disabling abandons any partial frame silently.
        if (!i_en) begin
            state_d     = IDLE;
            deliver     = 1'b0;
            frame_err_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            presc_en_q  <= 1'b0;
            scaler_q    <= DefaultDivider;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            presc_en_q  <= i_en;
            frame_err_q <= frame_err_d;
            overrun_q   <= deliver & valid_q & ~i_ready;
            if (state_q == IDLE) begin
                scaler_q <= clamp_divider(i_divider);
            end
            // An accept in the delivery cycle frees the slot for the new byte.
            if (deliver && (!valid_q || i_ready)) begin
                data_q  <= shreg_q;
                valid_q <= 1'b1;
            end else if (valid_q && i_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign o_presc_en     = presc_en_q;
    assign o_presc_scaler = scaler_q;
    assign o_data         = data_q;
    assign o_valid        = valid_q;
    assign o_frame_err    = frame_err_q;
    assign o_overrun      = overrun_q;
    assign o_busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl with a behavioural prescaler attached
// and a byte scoreboard drained by a valid/ready monitor.
module tb_uart_rx_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] divider;
    logic        rx;
    logic        presc_strobe;
    logic        presc_en;
    logic [15:0] presc_scaler;
    logic [7:0]  data;
    logic        valid;
    logic        ready;
    logic        frame_err;
    logic        overrun;
    logic        busy;

    logic [7:0]  exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          fe_cnt = 0;
    int          ov_cnt = 0;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [7:0]  prev_data = 8'h00;
    logic [15:0] pcnt;

    uart_rx_ctrl #(
        .OverSample     (8),
        .DataBits       (8),
        .DefaultDivider (16'd16)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_en           (en),
        .i_divider      (divider),
        .i_rx           (rx),
        .i_presc_strobe (presc_strobe),
        .o_presc_en     (presc_en),
        .o_presc_scaler (presc_scaler),
        .o_data         (data),
        .o_valid        (valid),
        .i_ready        (ready),
        .o_frame_err    (frame_err),
        .o_overrun      (overrun),
        .o_busy         (busy)
    );

    always #5 clk = ~clk;

    // Prescaler model: one strobe every presc_scaler clocks while enabled.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt         <= 16'd0;
            presc_strobe <= 1'b0;
        end else if (!presc_en) begin
            pcnt         <= 16'd0;
            presc_strobe <= 1'b0;
        end else if (pcnt >= presc_scaler - 16'd1) begin
            pcnt         <= 16'd0;
            presc_strobe <= 1'b1;
        end else begin
            pcnt         <= pcnt + 16'd1;
            presc_strobe <= 1'b0;
        end
    end

    // Consumer-side monitor: pops the scoreboard on each accepted byte.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (valid && ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL accept: unexpected byte %02h, scoreboard empty", data);
                end else begin
                    logic [7:0] exp;
                    exp = exp_q.pop_front();
                    if (data !== exp) begin
                        errors++;
                        $display("FAIL accept: o_data=%02h required %02h", data, exp);
                    end
                end
            end
            if (prev_valid && !prev_ready) begin
                checks++;
                if (valid !== 1'b1 || data !== prev_data) begin
                    errors++;
                    $display("FAIL hold: o_valid=%b o_data=%02h required 1/%02h", valid, data, prev_data);
                end
            end
            if (frame_err || overrun) begin
                checks++;
                if (frame_err && overrun) begin
                    errors++;
                    $display("FAIL pulse_excl: o_frame_err=1 o_overrun=1 required not both");
                end
            end
            if (frame_err) fe_cnt++;
            if (overrun)   ov_cnt++;
            prev_valid = valid;
            prev_ready = ready;
            prev_data  = data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves the line at the stop-bit level on return.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int bitclk);
        rx = 1'b0;
        clk_n(bitclk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            clk_n(bitclk);
        end
        rx = stop;
        clk_n(bitclk);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            clk_n(1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d bytes pending, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; rx = 1'b1; divider = 16'd4; ready = 1'b0;
        clk_n(3);
        checks++;
        if ({busy, presc_en, valid, frame_err, overrun} !== 5'b0 || data !== 8'h00 || presc_scaler !== 16'd16) begin
            errors++;
            $display("FAIL reset: busy/en/valid/fe/ov=%b data=%02h scaler=%0d required 00000/00/16",
                     {busy, presc_en, valid, frame_err, overrun}, data, presc_scaler);
        end
        rst = 1'b0;
        en  = 1'b1;
        clk_n(5);
        checks++;
        if (presc_en !== 1'b1 || presc_scaler !== 16'd4) begin
            errors++;
            $display("FAIL post_reset: presc_en=%b scaler=%0d required 1/4", presc_en, presc_scaler);
        end
    endtask

    task automatic test_clean_frame;
        int fe0, ov0, n;
        fe0 = fe_cnt; ov0 = ov_cnt;
        ready = 1'b0;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 32);
        n = 0;
        while (!valid && n < 40) begin
            clk_n(1);
            n++;
        end
        checks++;
        if (valid !== 1'b1 || data !== 8'hA5) begin
            errors++;
            $display("FAIL clean: o_valid=%b o_data=%02h required 1/a5", valid, data);
        end
        ready = 1'b1;
        clk_n(1);
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL clean_clear: o_valid=%b required 0", valid);
        end
        checks++;
        if (fe_cnt != fe0 || ov_cnt != ov0) begin
            errors++;
            $display("FAIL clean_pulses: fe=%0d ov=%0d required %0d/%0d", fe_cnt, ov_cnt, fe0, ov0);
        end
    endtask

    task automatic test_glitch_start;
        int fe0, ov0, n;
        fe0 = fe_cnt; ov0 = ov_cnt;
        ready = 1'b0;
        rx = 1'b0;
        clk_n(6);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_start: o_busy=%b required 1", busy);
        end
        rx = 1'b1;
        n = 0;
        while (busy && n < 20) begin
            clk_n(1);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_idle: o_busy=%b required 0", busy);
        end
        clk_n(40);
        checks++;
        if (valid !== 1'b0 || fe_cnt != fe0 || ov_cnt != ov0) begin
            errors++;
            $display("FAIL glitch_out: o_valid=%b fe=%0d ov=%0d required 0/%0d/%0d", valid, fe_cnt, ov_cnt, fe0, ov0);
        end
    endtask

    task automatic test_framing_error;
        int fe0;
        fe0 = fe_cnt;
        ready = 1'b0;
        send_frame(8'h3C, 1'b0, 32);
        clk_n(100);
        checks++;
        if (fe_cnt != fe0 + 1 || valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL frame_err: fe=%0d o_valid=%b o_busy=%b required %0d/0/1", fe_cnt, valid, busy, fe0 + 1);
        end
        rx = 1'b1;
        clk_n(5);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL break_exit: o_busy=%b required 0", busy);
        end
        ready = 1'b1;
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, 32);
        wait_drain("after_break", 60);
    endtask

    task automatic test_overrun;
        int ov0;
        ov0 = ov_cnt;
        ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 32);
        send_frame(8'h22, 1'b1, 32);
        clk_n(10);
        checks++;
        if (ov_cnt != ov0 + 1 || valid !== 1'b1 || data !== 8'h11) begin
            errors++;
            $display("FAIL overrun: ov=%0d o_valid=%b o_data=%02h required %0d/1/11", ov_cnt, valid, data, ov0 + 1);
        end
        ready = 1'b1;
        wait_drain("overrun_drain", 20);
    endtask

    task automatic test_ready_at_completion;
        int  ov0;
        logic hit;
        ov0 = ov_cnt;
        hit = 1'b0;
        ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 32);
        exp_q.push_back(8'h22);
        fork
            send_frame(8'h22, 1'b1, 32);
            begin
                for (int n = 0; n < 700 && !hit; n++) begin
                    @(posedge clk);
                    #2;
                    if (dut.deliver) begin
                        ready = 1'b1;
                        @(posedge clk);
                        #1;
                        ready = 1'b0;
                        hit = 1'b1;
                    end
                end
            end
        join
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL same_cycle: delivery of 22 not seen within budget, required within 700 clocks");
        end
        clk_n(5);
        checks++;
        if (ov_cnt != ov0 || valid !== 1'b1 || data !== 8'h22) begin
            errors++;
            $display("FAIL same_cycle: ov=%0d o_valid=%b o_data=%02h required %0d/1/22", ov_cnt, valid, data, ov0);
        end
        ready = 1'b1;
        wait_drain("same_cycle_drain", 20);
    endtask

    task automatic test_divider;
        ready = 1'b1;
        exp_q.push_back(8'h96);
        fork
            send_frame(8'h96, 1'b1, 32);
            begin
                clk_n(64);
                divider = 16'd8;
                clk_n(20);
                checks++;
                if (presc_scaler !== 16'd4) begin
                    errors++;
                    $display("FAIL div_midframe: scaler=%0d required 4", presc_scaler);
                end
            end
        join
        clk_n(5);
        checks++;
        if (presc_scaler !== 16'd8) begin
            errors++;
            $display("FAIL div_idle: scaler=%0d required 8", presc_scaler);
        end
        wait_drain("div_first", 20);
        exp_q.push_back(8'h69);
        send_frame(8'h69, 1'b1, 64);
        wait_drain("div_second", 60);
        divider = 16'd0;
        clk_n(3);
        checks++;
        if (presc_scaler !== 16'd2) begin
            errors++;
            $display("FAIL div_clamp0: scaler=%0d required 2", presc_scaler);
        end
        divider = 16'd1;
        clk_n(3);
        checks++;
        if (presc_scaler !== 16'd2) begin
            errors++;
            $display("FAIL div_clamp1: scaler=%0d required 2", presc_scaler);
        end
        divider = 16'd4;
        clk_n(3);
    endtask

    task automatic test_enable;
        logic [7:0] d;
        d = 8'hF0;
        ready = 1'b0;
        rx = 1'b0;
        clk_n(32);
        for (int i = 0; i < 3; i++) begin
            rx = d[i];
            clk_n(32);
        end
        rx = d[3];
        clk_n(16);
        en = 1'b0;
        clk_n(1);
        checks++;
        if (presc_en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL disable: presc_en=%b o_busy=%b required 0/0", presc_en, busy);
        end
        clk_n(15);
        for (int i = 4; i < 8; i++) begin
            rx = d[i];
            clk_n(32);
        end
        rx = 1'b1;
        clk_n(42);
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL disabled_out: o_valid=%b o_busy=%b required 0/0", valid, busy);
        end
        en = 1'b1;
        clk_n(5);
        ready = 1'b1;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 32);
        wait_drain("reenable", 60);
    endtask

    task automatic test_reset_midframe;
        ready = 1'b0;
        rx = 1'b0;
        clk_n(32 * 3 + 10);
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, presc_en, valid, frame_err, overrun} !== 5'b0 || data !== 8'h00 || presc_scaler !== 16'd16) begin
            errors++;
            $display("FAIL reset_mid: busy/en/valid/fe/ov=%b data=%02h scaler=%0d required 00000/00/16",
                     {busy, presc_en, valid, frame_err, overrun}, data, presc_scaler);
        end
        rx = 1'b1;
        clk_n(2);
        rst = 1'b0;
        clk_n(5);
        checks++;
        if (presc_scaler !== 16'd4 || presc_en !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_recover: scaler=%0d presc_en=%b required 4/1", presc_scaler, presc_en);
        end
        ready = 1'b1;
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1, 32);
        wait_drain("post_reset_frame", 60);
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_glitch_start();
        test_framing_error();
        test_overrun();
        test_ready_at_completion();
        test_divider();
        test_enable();
        test_reset_midframe();
        clk_n(10);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
